hamming_secded_codec: RTL and testbench
=======================================

HAMMING_SECDED_CODEC -- requirements
Module: hamming_secded_codec

Interface
REQ-001 SHALL have parameter DATA_W, default 8: payload width, legal range 4..57.
REQ-002 SHALL have parameter CNT_W, default 16: width of each error counter.
REQ-003 SHALL derive localparams R (smallest r with 2^r >= DATA_W+r+1) and CODE_W = DATA_W+R+1 (R=4, CODE_W=13 at default).
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1: request present.
REQ-007 SHALL have port in_ready, output, 1: request accepted when high with in_valid.
REQ-008 SHALL have port in_mode, input, 1: 0 encode, 1 decode.
REQ-009 SHALL have port in_data, input, CODE_W: decode codeword; encode uses bits [DATA_W-1:0] and ignores the rest.
REQ-010 SHALL have port out_valid, output, 1: result present.
REQ-011 SHALL have port out_ready, input, 1: result consumed when high with out_valid.
REQ-012 SHALL have port out_mode, output, 1: mode of the presented result.
REQ-013 SHALL have port out_data, output, CODE_W: codeword (encode) or corrected payload zero-extended (decode).
REQ-014 SHALL have ports out_syndrome (output, R), out_sec (output, 1, single error corrected) and out_ded (output, 1, uncorrectable error).
REQ-015 SHALL have ports cnt_clr (input, 1, synchronous clear), sec_cnt (output, CNT_W) and ded_cnt (output, CNT_W).

Function
REQ-016 Codeword layout SHALL be: Hamming position p (1..CODE_W-1) at bit CODE_W-1-(p-1); overall even parity P0 at bit 0; parity bits at power-of-two positions.
REQ-017 Payload bits SHALL fill non-power-of-two positions in ascending order, payload MSB at the lowest position, so out_data[12:1] at DATA_W=8 matches the existing 12-bit format.
REQ-018 Parity bit 2^k SHALL be the XOR of all positions whose index has bit k set; P0 SHALL be the XOR of positions 1..CODE_W-1.
REQ-019 Decode: S = recomputed syndrome, Q = XOR of all CODE_W bits.
- S=0, Q=0: clean.
- Q=1, S=0: P0 error, sec=1.
- Q=1, 1<=S<=CODE_W-1: flip position S, sec=1.
- Q=1, S>CODE_W-1: ded=1.
- Q=0, S!=0: ded=1, payload passed uncorrected.
REQ-020 In encode mode, out_sec, out_ded and out_syndrome SHALL be 0.
REQ-021 Pipeline SHALL have two register stages: S1 holds input and syndrome/Q, S2 holds the corrected result; latency SHALL be 2 cycles from accept to out_valid with no stall.
REQ-022 Throughput SHALL be one transaction per cycle while out_ready=1; modes MAY interleave on consecutive beats.
REQ-023 Stall rule: S2 loads when !out_valid or out_ready; S1 loads when S1 is empty or S2 loads; in_ready SHALL equal the S1 load condition.
REQ-024 Outputs SHALL hold stable while out_valid=1 and out_ready=0; no beat SHALL be dropped or duplicated.
REQ-025 Counters SHALL increment on an out_valid&out_ready decode beat with sec (sec_cnt) or ded (ded_cnt), and SHALL saturate at all-ones.
REQ-026 When cnt_clr and an increment occur in the same cycle, the counter SHALL read 0 on the next cycle.

Reset
REQ-027 rst_n low SHALL immediately clear both stage valids, discard in-flight beats, and zero out_valid, out_data, out_mode, out_syndrome, out_sec, out_ded, sec_cnt and ded_cnt; in_ready SHALL be 1 from the first edge after release.

Configuration
REQ-028 With HAMMING_ERR_CNT_EN defined, counters SHALL behave per REQ-025/026; without it, the counter registers SHALL be absent, sec_cnt and ded_cnt SHALL be tied to 0, cnt_clr SHALL be ignored, and all ports SHALL remain.

Structure
REQ-029 Package hamming_pkg SHALL hold the R/CODE_W calculation function, the mode constants ENC=0/DEC=1, and the payload-to-position mapping function.
REQ-030 Sub-module hamming_syndrome (combinational, parameter DATA_W) SHALL compute parity/syndrome and Q, and SHALL be shared by the encode and decode paths.

Verification
REQ-031 Encode 0xA5 (DATA_W=8) -> out_data=0x1C8A two cycles later, sec=ded=0.
REQ-032 Decode 0x1D8A (position 5 flipped) -> out_data=0x0A5, syndrome=5, sec=1; decode 0x1C8B (P0 flipped) -> 0x0A5, syndrome=0, sec=1.
REQ-033 Decode 0x1D0A (positions 5 and 6 flipped) -> syndrome=3, ded=1, sec=0, ded_cnt increments by 1.
REQ-034 Stream 10 beats with out_ready toggled randomly -> 10 results in order, each stable while stalled, in_ready low only while both stages are full.
REQ-035 CNT_W=4 with 20 single-error decodes -> sec_cnt saturates at 0xF; cnt_clr on an incrementing beat -> 0.
REQ-036 Assert rst_n low with 2 beats in flight -> outputs and counters zero at once, no stale beat after release.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared constants and helper functions for the Hamming SECDED codec.
// Covers parity-width sizing, the mode encoding and the payload-to-position map.
package hamming_pkg;

    localparam logic ENC = 1'b0;
    localparam logic DEC = 1'b1;

    function automatic int calc_r(input int dw);
        int r;
        r = 0;
        for (int k = 7; k >= 1; k--) begin
            if ((1 << k) >= dw + k + 1) r = k;
        end
        return r;
    endfunction

    function automatic int code_w(input int dw);
        return dw + calc_r(dw) + 1;
    endfunction

    // Hamming position of the j-th payload slot; slot 0 carries the payload MSB.
    function automatic int data_pos(input int j);
        int p;
        int n;
        p = 0;
        n = 0;
        for (int q = 1; q < 128; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (n == j) p = q;
                n++;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity generator.
// Used for both encode (parity slots zero) and decode (full codeword).
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int R      = calc_r(DATA_W),
    localparam int CODE_W = DATA_W + R + 1
) (
    input  logic [CODE_W-1:0] i_word,
    output logic [R-1:0]      o_syn,
    output logic              o_q
);

    always_comb begin
        o_syn = '0;
        for (int p = 1; p < CODE_W; p++) begin
            if (i_word[CODE_W-p]) o_syn = o_syn ^ R'(p);
        end
    end

    assign o_q = ^i_word;

endmodule

// File: rtl/hamming_secded_codec.sv
// Two-stage pipelined Hamming SECDED encoder/decoder with valid/ready flow.
// Define HAMMING_ERR_CNT_EN to build the saturating sec/ded error counters.
module hamming_secded_codec
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 16,
    localparam int R      = calc_r(DATA_W),
    localparam int CODE_W = DATA_W + R + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [CODE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mode,
    output logic [CODE_W-1:0] out_data,
    output logic [R-1:0]      out_syndrome,
    output logic              out_sec,
    output logic              out_ded,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt
);

    logic              w_s1_load, w_s2_load;
    logic [CODE_W-1:0] w_enc_word, w_word;
    logic [R-1:0]      w_syn;
    logic              w_q;

    logic              r1_valid, r1_mode, r1_q;
    logic [CODE_W-1:0] r1_word;
    logic [R-1:0]      r1_syn;

    logic              r2_valid, r2_mode, r2_sec, r2_ded;
    logic [CODE_W-1:0] r2_data;
    logic [R-1:0]      r2_syn;

    logic [CODE_W-1:0] w_fix, w_res;
    logic [R-1:0]      w_syn_o;
    logic              w_hit, w_sec, w_ded;

    assign w_s2_load = !r2_valid || out_ready;
    assign w_s1_load = !r1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    always_comb begin
        w_enc_word = '0;
        for (int j = 0; j < DATA_W; j++) begin
            w_enc_word[CODE_W-data_pos(j)] = in_data[DATA_W-1-j];
        end
    end

    assign w_word = (in_mode == DEC) ? in_data : w_enc_word;

    hamming_syndrome #(.DATA_W(DATA_W)) u_syn (
        .i_word (w_word),
        .o_syn  (w_syn),
        .o_q    (w_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_mode  <= ENC;
            r1_word  <= '0;
            r1_syn   <= '0;
            r1_q     <= 1'b0;
        end else if (w_s1_load) begin
            r1_valid <= in_valid;
            r1_mode  <= in_mode;
            r1_word  <= w_word;
            r1_syn   <= w_syn;
            r1_q     <= w_q;
        end
    end

    // Encode fills parity slots from the syndrome; decode corrects and extracts.
    always_comb begin
        w_fix   = r1_word;
        w_res   = '0;
        w_syn_o = '0;
        w_hit   = 1'b0;
        w_sec   = 1'b0;
        w_ded   = 1'b0;
        if (r1_mode == ENC) begin
            for (int k = 0; k < R; k++) begin
                w_fix[CODE_W-(1<<k)] = r1_syn[k];
            end
            w_fix[0] = r1_q ^ (^r1_syn);
            w_res    = w_fix;
        end else begin
            w_syn_o = r1_syn;
            for (int p = 1; p < CODE_W; p++) begin
                if (r1_syn == R'(p)) w_hit = 1'b1;
            end
            if (r1_q) begin
                if (r1_syn == '0) begin
                    w_sec    = 1'b1;
                    w_fix[0] = ~w_fix[0];
                end else if (w_hit) begin
                    w_sec = 1'b1;
                    for (int p = 1; p < CODE_W; p++) begin
                        if (r1_syn == R'(p)) w_fix[CODE_W-p] = ~w_fix[CODE_W-p];
                    end
                end else begin
                    w_ded = 1'b1;
                end
            end else if (r1_syn != '0) begin
                w_ded = 1'b1;
            end
            for (int j = 0; j < DATA_W; j++) begin
                w_res[DATA_W-1-j] = w_fix[CODE_W-data_pos(j)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid <= 1'b0;
            r2_mode  <= ENC;
            r2_data  <= '0;
            r2_syn   <= '0;
            r2_sec   <= 1'b0;
            r2_ded   <= 1'b0;
        end else if (w_s2_load) begin
            r2_valid <= r1_valid;
            r2_mode  <= r1_mode;
            r2_data  <= w_res;
            r2_syn   <= w_syn_o;
            r2_sec   <= w_sec;
            r2_ded   <= w_ded;
        end
    end

    assign out_valid    = r2_valid;
    assign out_mode     = r2_mode;
    assign out_data     = r2_data;
    assign out_syndrome = r2_syn;
    assign out_sec      = r2_sec;
    assign out_ded      = r2_ded;

`ifdef HAMMING_ERR_CNT_EN
    logic [CNT_W-1:0] r_sec_cnt, r_ded_cnt;
    logic             w_beat;

    assign w_beat = r2_valid && out_ready && (r2_mode == DEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else begin
            if (cnt_clr)
                r_sec_cnt <= '0;
            else if (w_beat && r2_sec && r_sec_cnt != '1)
                r_sec_cnt <= r_sec_cnt + CNT_W'(1);
            if (cnt_clr)
                r_ded_cnt <= '0;
            else if (w_beat && r2_ded && r_ded_cnt != '1)
                r_ded_cnt <= r_ded_cnt + CNT_W'(1);
        end
    end

    assign sec_cnt = r_sec_cnt;
    assign ded_cnt = r_ded_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr = cnt_clr;
    assign sec_cnt      = '0;
    assign ded_cnt      = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Directed and randomized bench for hamming_secded_codec (DATA_W=8, CNT_W=4).
// Reference decode searches for the nearest codeword rather than using syndromes.
module tb_hamming_secded_codec;

    localparam int DW   = 8;
    localparam int CW   = 13;
    localparam int RW   = 4;
    localparam int CNTW = 4;
`ifdef HAMMING_ERR_CNT_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_mode = 1'b0;
    logic [CW-1:0]   in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            out_mode;
    logic [CW-1:0]   out_data;
    logic [RW-1:0]   out_syndrome;
    logic            out_sec;
    logic            out_ded;
    logic            cnt_clr = 1'b0;
    logic [CNTW-1:0] sec_cnt;
    logic [CNTW-1:0] ded_cnt;

    always #5 clk = ~clk;

    hamming_secded_codec #(.DATA_W(DW), .CNT_W(CNTW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_mode     (out_mode),
        .out_data     (out_data),
        .out_syndrome (out_syndrome),
        .out_sec      (out_sec),
        .out_ded      (out_ded),
        .cnt_clr      (cnt_clr),
        .sec_cnt      (sec_cnt),
        .ded_cnt      (ded_cnt)
    );

    typedef struct {
        logic          mode;
        logic [CW-1:0] data;
        logic [RW-1:0] syn;
        logic          sec;
        logic          ded;
    } res_t;

    res_t q[$];
    int   acc_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_push = 0;
    int   n_pop = 0;
    int   sec_m = 0;
    int   ded_m = 0;
    bit   held = 1'b0;
    res_t snap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: positions 1..12 live at bit 13-p, P0 at bit 0.
    function automatic logic [CW-1:0] place(input logic [DW-1:0] d);
        logic [CW-1:0] w;
        int j;
        w = '0;
        j = DW - 1;
        for (int p = 1; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                w[CW-p] = d[j];
                j--;
            end
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] extract(input logic [CW-1:0] w);
        logic [DW-1:0] d;
        int j;
        d = '0;
        j = DW - 1;
        for (int p = 1; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[j] = w[CW-p];
                j--;
            end
        end
        return d;
    endfunction

    function automatic int synd(input logic [CW-1:0] w);
        int s;
        s = 0;
        for (int p = 1; p < CW; p++) if (w[CW-p]) s = s ^ p;
        return s;
    endfunction

    function automatic logic [CW-1:0] enc(input logic [DW-1:0] d);
        logic [CW-1:0] w;
        int s;
        w = place(d);
        s = synd(w);
        for (int k = 0; k < RW; k++) if (((s >> k) & 1) != 0) w[CW-(1<<k)] = 1'b1;
        w[0] = ^w;
        return w;
    endfunction

    function automatic bit is_cw(input logic [CW-1:0] w);
        return enc(extract(w)) == w;
    endfunction

    function automatic res_t model(input logic m, input logic [CW-1:0] w);
        res_t r;
        logic [CW-1:0] c;
        logic [CW-1:0] x;
        r.mode = m;
        r.syn  = '0;
        r.sec  = 1'b0;
        r.ded  = 1'b0;
        if (!m) begin
            r.data = enc(w[DW-1:0]);
            return r;
        end
        r.syn = RW'(synd(w));
        c = w;
        if (!is_cw(w)) begin
            r.ded = 1'b1;
            for (int i = 0; i < CW; i++) begin
                x = w ^ (CW'(1) << i);
                if (is_cw(x)) begin
                    c     = x;
                    r.sec = 1'b1;
                    r.ded = 1'b0;
                end
            end
        end
        r.data = CW'(extract(c));
        return r;
    endfunction

    function automatic logic [CW-1:0] rnd_word();
        logic [CW-1:0] w;
        int a;
        int b;
        w = enc(DW'($urandom));
        a = $urandom_range(0, CW - 1);
        b = (a + $urandom_range(1, CW - 1)) % CW;
        case ($urandom_range(0, 3))
            0: ;
            1: w[a] = ~w[a];
            2: begin w[a] = ~w[a]; w[b] = ~w[b]; end
            default: w = CW'($urandom);
        endcase
        return w;
    endfunction

    // One clock: sample before the edge, account handshakes, check counters after.
    task automatic tick();
        res_t e;
        bit   ev;
        #1;
        ev = (q.size() > 0) && (cyc >= acc_q[0] + 2);
        chk("out_valid", out_valid, ev);
        chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
        if (held) begin
            chk("hold_mode", out_mode, snap.mode);
            chk("hold_data", out_data, snap.data);
            chk("hold_syn", out_syndrome, snap.syn);
            chk("hold_flags", {out_sec, out_ded}, {snap.sec, snap.ded});
        end
        held      = out_valid && !out_ready;
        snap.mode = out_mode;
        snap.data = out_data;
        snap.syn  = out_syndrome;
        snap.sec  = out_sec;
        snap.ded  = out_ded;
        if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            void'(acc_q.pop_front());
            n_pop++;
            chk("res_mode", out_mode, e.mode);
            chk("res_data", out_data, e.data);
            chk("res_syn", out_syndrome, e.syn);
            chk("res_sec", out_sec, e.sec);
            chk("res_ded", out_ded, e.ded);
            if (e.mode && e.sec && sec_m < 15) sec_m++;
            if (e.mode && e.ded && ded_m < 15) ded_m++;
        end
        if (cnt_clr) begin
            sec_m = 0;
            ded_m = 0;
        end
        if (in_valid && in_ready) begin
            q.push_back(model(in_mode, in_data));
            acc_q.push_back(cyc);
            n_push++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("sec_cnt", sec_cnt, CEN ? sec_m : 0);
        chk("ded_cnt", ded_cnt, CEN ? ded_m : 0);
    endtask

    task automatic run1(input logic m, input logic [CW-1:0] d, input logic [CW-1:0] ed,
                        input logic [RW-1:0] es, input logic esec, input logic eded);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = m;
        in_data   = d;
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        chk("dir_valid", out_valid, 1);
        chk("dir_data", out_data, ed);
        chk("dir_syn", out_syndrome, es);
        chk("dir_sec", out_sec, esec);
        chk("dir_ded", out_ded, eded);
        tick();
    endtask

    initial begin
        int base_push;
        int base_pop;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_flags", {out_mode, out_sec, out_ded}, 0);
        chk("rst_syn", out_syndrome, 0);
        chk("rst_cnt", {sec_cnt, ded_cnt}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        run1(1'b0, 13'h00A5, 13'h1C8A, 4'd0, 1'b0, 1'b0);
        run1(1'b1, 13'h1D8A, 13'h00A5, 4'd5, 1'b1, 1'b0);
        run1(1'b1, 13'h1C8B, 13'h00A5, 4'd0, 1'b1, 1'b0);
        run1(1'b1, 13'h1D0A, 13'h00C5, 4'd3, 1'b0, 1'b1);
        chk("ded_once", ded_cnt, CEN ? 1 : 0);

        base_push = n_push;
        base_pop  = n_pop;
        for (int c = 0; c < 300 && !(n_push - base_push == 10 && q.size() == 0); c++) begin
            in_valid  = (n_push - base_push < 10) && ($urandom_range(0, 3) != 0);
            in_mode   = 1'($urandom);
            in_data   = in_mode ? rnd_word() : CW'($urandom);
            out_ready = 1'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_drain", q.size(), 0);
        chk("stream_count", n_pop - base_pop, 10);

        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_mode  = 1'b1;
            in_data  = enc(DW'($urandom)) ^ (CW'(1) << $urandom_range(0, CW - 1));
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("sec_sat", sec_cnt, CEN ? 15 : 0);

        in_valid = 1'b1;
        in_mode  = 1'b1;
        in_data  = 13'h1D8A;
        tick();
        in_valid = 1'b0;
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("sec_clr", sec_cnt, 0);

        run1(1'b1, 13'h1C8B, 13'h00A5, 4'd0, 1'b1, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b1;
        in_data   = 13'h1D8A;
        tick();
        in_mode = 1'b0;
        in_data = 13'h005A;
        tick();
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_flags", {out_mode, out_sec, out_ded}, 0);
        chk("mid_rst_syn", out_syndrome, 0);
        chk("mid_rst_cnt", {sec_cnt, ded_cnt}, 0);
        q.delete();
        acc_q.delete();
        sec_m = 0;
        ded_m = 0;
        held  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
